// File: rtl/gp_cmd_fetch_if.sv
// gp_cmd_fetch_if: kick, memory read and draw-command channels of the GP command fetcher
interface gp_cmd_fetch_if;
   logic [31:0] gp_code;
   logic [31:0] gp_frame;
   logic        gp_valid;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd_op;
   logic [31:0] cmd_arg0;
   logic [31:0] cmd_arg1;
   logic [31:0] cmd_arg2;
   logic [31:0] cmd_frame;
   modport slave (
      input  gp_code, gp_frame, gp_valid, mem_ack, mem_rdata, cmd_ready,
      output mem_req, mem_addr, cmd_valid, cmd_op, cmd_arg0, cmd_arg1, cmd_arg2, cmd_frame
   );
   modport master (
      output gp_code, gp_frame, gp_valid, mem_ack, mem_rdata, cmd_ready,
      input  mem_req, mem_addr, cmd_valid, cmd_op, cmd_arg0, cmd_arg1, cmd_arg2, cmd_frame
   );
endinterface

// File: rtl/gp_cmd_fetch.sv
// gp_cmd_fetch: walks GP command lists from memory and issues decoded draw commands
module gp_cmd_fetch #(
   parameter int MAX_CMDS = 1024,
   parameter int CNT_W    = 11
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          vsync,
   gp_cmd_fetch_if.slave bus,
   output logic          frame_interrupt,
   output logic          busy,
   output logic          list_done,
   output logic          list_err
);
   typedef enum logic [2:0] {IDLE, FETCH0, FETCHA, ISSUE, END} state_t;
   state_t           state, nxt;
   logic [31:0]      addr, frame, pend_code, pend_frame, arg1, arg2;
   logic [23:0]      imm;
   logic [7:0]       op, rop;
   logic [CNT_W-1:0] cnt, cnt_inc;
   logic [1:0]       rem;
   logic             pend, vsync_q, err, ack, start, fire, wd;
   assign bus.mem_req   = state == FETCH0 || state == FETCHA;
   assign bus.mem_addr  = addr;
   assign bus.cmd_valid = state == ISSUE;
   assign bus.cmd_op    = op;
   assign bus.cmd_arg0  = {8'd0, imm};
   assign bus.cmd_arg1  = arg1;
   assign bus.cmd_arg2  = arg2;
   assign bus.cmd_frame = frame;
   assign busy      = state != IDLE || pend;
   assign list_done = state == END;
   assign list_err  = err;
   assign ack     = bus.mem_req & bus.mem_ack;
   assign rop     = bus.mem_rdata[31:24];
   assign fire    = state == ISSUE && bus.cmd_ready;
   assign cnt_inc = cnt + 1'b1;
   assign wd      = cnt_inc == CNT_W'(MAX_CMDS);
   // a kick arriving in END is newer than the pending slot, so it wins
   assign start = (state == IDLE && bus.gp_valid) || (state == END && (pend || bus.gp_valid));
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = bus.gp_valid ? FETCH0 : IDLE;
         FETCH0:  if (ack) nxt = rop == 8'h01 ? ISSUE : (rop == 8'h02 || rop == 8'h03) ? FETCHA : END;
         FETCHA:  if (ack && rem == 2'd1) nxt = ISSUE;
         ISSUE:   if (bus.cmd_ready) nxt = wd ? END : FETCH0;
         default: nxt = start ? FETCH0 : IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= nxt;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr            <= '0;
         frame           <= '0;
         pend            <= 1'b0;
         pend_code       <= '0;
         pend_frame      <= '0;
         cnt             <= '0;
         rem             <= '0;
         op              <= '0;
         imm             <= '0;
         arg1            <= '0;
         arg2            <= '0;
         err             <= 1'b0;
         vsync_q         <= 1'b0;
         frame_interrupt <= 1'b0;
      end else begin
         vsync_q         <= vsync;
         frame_interrupt <= vsync & ~vsync_q;
         if (start) begin
            addr  <= (bus.gp_valid ? bus.gp_code : pend_code) & ~32'd3;
            frame <= bus.gp_valid ? bus.gp_frame : pend_frame;
            cnt   <= '0;
            err   <= 1'b0;
         end else if (ack) addr <= addr + 32'd4;
         if (bus.gp_valid && state != IDLE && state != END) begin
            pend       <= 1'b1;
            pend_code  <= bus.gp_code;
            pend_frame <= bus.gp_frame;
         end else if (state == END) pend <= 1'b0;
         if (ack && state == FETCH0) begin
            op   <= rop;
            imm  <= bus.mem_rdata[23:0];
            arg1 <= '0;
            arg2 <= '0;
            rem  <= 2'd2;
            if (rop > 8'h03) err <= 1'b1;
         end
         if (ack && state == FETCHA) begin
            if (rem == 2'd2) arg1 <= bus.mem_rdata;
            else arg2 <= bus.mem_rdata;
            rem <= rem - 1'b1;
         end
         if (fire) begin
            cnt <= cnt_inc;
            if (wd) err <= 1'b1;
         end
      end
   end
endmodule

// File: doc/gp_cmd_fetch.md
Name: gp_cmd_fetch

Overview:
- Graphics-side responder for the CPU's graphics-processor command interface: consumes the `gp_code` / `gp_frame` / `gp_valid` triple and returns `frame_interrupt`.
- On each command-list kick it walks the list in memory over a req/ack read port and decodes variable-length commands.
- Decoded commands go to the drawing engine over a valid/ready handshake.
- Sits between the CPU top level, the memory arbiter and the drawing engine.

Parameters:
- MAX_CMDS, 1024: watchdog; maximum commands per list before forced abort.
- CNT_W, 11: width of the per-list command counter; must satisfy 2^CNT_W > MAX_CMDS.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- gp_code  in  32  byte address of command list
- gp_frame  in  32  frame buffer base for that list
- gp_valid  in  1  one-cycle kick; `gp_code`/`gp_frame` valid this cycle
- vsync  in  1  display vertical sync level
- frame_interrupt  out  1  one-cycle pulse per vsync rising edge
- mem_req  out  1  read request
- mem_addr  out  32  word-aligned read address
- mem_ack  in  1  read complete; `mem_rdata` valid this cycle
- mem_rdata  in  32  read data
- cmd_valid  out  1  decoded command available
- cmd_ready  in  1  drawing engine accepts
- cmd_op  out  8  opcode
- cmd_arg0  out  32  command word 0 with `[31:24]` zeroed (colour/imm)
- cmd_arg1  out  32  argument word 1 (0 if unused)
- cmd_arg2  out  32  argument word 2 (0 if unused)
- cmd_frame  out  32  frame base latched for the current list
- busy  out  1  list in progress or pending
- list_done  out  1  one-cycle pulse when a list terminates
- list_err  out  1  sticky; set on illegal opcode or watchdog; cleared by the next accepted kick

Behaviour:
- Reset (async, `rst_n` = 0):
  - all outputs 0; FSM = IDLE; pending slot empty; vsync edge register = 0.
- Command format:
  - Word0 `[31:24]` = opcode.
  - 0x00 STOP: 1 word, not issued.
  - 0x01 FILL: 1 word.
  - 0x02 LINE: 3 words (word1 = {y0,x0}, word2 = {y1,x1}, 16 bits each).
  - 0x03 RECT: 3 words, same layout as LINE.
  - Any other opcode is illegal: treated as STOP, sets `list_err`, not issued.
- Kick handling:
  - `gp_valid` in IDLE: latch `gp_code & ~3` into the address register and `gp_frame` into `cmd_frame`; clear the counter and `list_err`; go to FETCH0 the next cycle.
  - `gp_valid` when not IDLE: store into a one-deep pending slot; a later kick overwrites it (last wins).
  - `busy` = (state != IDLE) | pending.
- FSM states:
  - IDLE
  - FETCH0: read word0.
  - FETCHA: read args.
  - ISSUE
  - END
- Memory handshake:
  - `mem_req` is asserted in FETCH0/FETCHA; `mem_addr` is held stable until `mem_ack`.
  - `mem_ack` may arrive the same cycle `mem_req` rises (zero-wait) or any number of cycles later.
  - On ack, the address increments by 4 (32-bit wrap, no error at wrap).
  - `mem_req` deasserts the cycle after ack unless another word is needed, in which case it stays high.
  - `mem_ack` while `mem_req` is low is ignored.
- FETCH0 on ack:
  - STOP or illegal → END.
  - FILL → ISSUE.
  - LINE/RECT → FETCHA with 2 words remaining.
- FETCHA: the remaining count decrements on each ack; after the last ack → ISSUE.
- ISSUE:
  - `cmd_valid` = 1; `cmd_*` fields are stable until `cmd_ready`.
  - On `cmd_valid & cmd_ready`: counter increments; if counter + 1 == MAX_CMDS → set `list_err`, go to END; else → FETCH0.
  - No fetch-ahead while stalled on `cmd_ready`.
- END:
  - `list_done` pulses for 1 cycle.
  - If pending: load the pending slot (as a kick) and go to FETCH0.
  - Else go to IDLE.
  - A `gp_valid` in the END cycle goes to pending and is consumed the same cycle.
- frame_interrupt: `vsync & ~vsync_q`, registered; exactly one-cycle pulse per rising edge; independent of FSM state.
- Latency, FILL at zero-wait memory: kick → `mem_req` 1 cycle; ack → `cmd_valid` next cycle.

Test Plan:
- List at 0x10000000 = {0x01FF0000, 0x00000000}, zero-wait ack, `cmd_ready` = 1 → one issue with `cmd_op`=0x01, `cmd_arg0`=0x00FF0000, `cmd_frame`=kick value. `mem_addr` sequence 0x10000000, 0x10000004. `list_done` pulses once; `busy` falls.
- LINE {0x02000011, 0x00050003, 0x000A0007, STOP}, 3-cycle ack latency, `cmd_ready` low 5 cycles → `cmd_arg1`=0x00050003, `cmd_arg2`=0x000A0007 held stable; `mem_addr` held through each wait; no req during stall.
- Opcode 0x7F as first word → no `cmd_valid`, `list_err` = 1, `list_done` pulse. Next kick clears `list_err`.
- Kicks A, B, C while list A is active → after A's STOP only C executes; `busy` stays high continuously across the A→C transition.
- List of 1030 FILLs with MAX_CMDS = 1024 → exactly 1024 issues, then `list_err` = 1 and `list_done`; `gp_code` = 0xFFFFFFFC wraps `mem_addr` to 0x00000000.
- `vsync` held high 100 cycles, twice → exactly 2 `frame_interrupt` pulses. `rst_n` low mid-FETCHA → `mem_req`, `cmd_valid`, `busy` = 0 immediately (async).
